// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default
// bus geometry and the RAM-page region decode.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ACC  = 2'd1,
    ST_RD_HOLD = 2'd2,
    ST_WR_WAIT = 2'd3
  } state_t;

  localparam int           DEF_ADDR_W   = 13;
  localparam int           DEF_DATA_W   = 8;
  localparam logic [4:0]   DEF_RAM_PAGE = 5'h1F;
  localparam int           PAGE_DEPTH   = 256;

  // Page numbers are zero-extended to 16 bits so one function serves any ADDR_W.
  function automatic logic in_ram_page(input logic [15:0] page,
                                       input logic [15:0] ram_page);
    return page == ram_page;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU/ROM bus bundle for mem_responder.
// master: CPU sequencer plus ROM data source; slave: the responder.
// Optional counters are present only when MEM_RESPONDER_STATS_EN is defined.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] rdata;
  logic              rdata_vld;
  logic              err_ro;
  logic              err_col;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;
`endif

  modport master (
    output addr, rd, wr, wdata, rom_data,
    input  rom_ce, rom_addr, rdata, rdata_vld, err_ro, err_col
`ifdef MEM_RESPONDER_STATS_EN
    , input rd_cnt, wr_cnt
`endif
  );

  modport slave (
    input  addr, rd, wr, wdata, rom_data,
    output rom_ce, rom_addr, rdata, rdata_vld, err_ro, err_col
`ifdef MEM_RESPONDER_STATS_EN
    , output rd_cnt, wr_cnt
`endif
  );

endinterface

// File: rtl/mem_responder_ram_page.sv
// 256 x DATA_W internal RAM page: synchronous write, asynchronous read.
module ram_page
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [PAGE_DEPTH];

  // Commit one word per enabled edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Bus responder for the CPU control interface: serves reads from the
// external ROM or the internal RAM page and commits writes to the RAM page.
// Optional feature macro: MEM_RESPONDER_STATS_EN (saturating rd/wr counters).
module mem_responder
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-9:0] RAM_PAGE = DEF_RAM_PAGE
) (
  input logic            clk,
  input logic            rst_n,
  mem_responder_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              vld_q, vld_d;
  logic              err_ro_q, err_ro_d;
  logic              err_col_q, err_col_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              addr_is_ram;
  logic              lat_is_ram;

  assign addr_is_ram = in_ram_page(16'(bus.addr[ADDR_W-1:8]), 16'(RAM_PAGE));
  assign lat_is_ram  = in_ram_page(16'(lat_addr_q[ADDR_W-1:8]), 16'(RAM_PAGE));

  // A reset in the same cycle as the write cancels the commit.
  ram_page #(.DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we && rst_n),
    .waddr (bus.addr[7:0]),
    .wdata (bus.wdata),
    .raddr (lat_addr_q[7:0]),
    .rdata (ram_rdata)
  );

  // Next-state and registered-output decode; every value holds by default.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    rom_ce_d   = rom_ce_q;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    vld_d      = vld_q;
    err_ro_d   = err_ro_q;
    err_col_d  = err_col_q;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rd && bus.wr) begin
          err_col_d = 1'b1;
        end else if (bus.rd) begin
          lat_addr_d = bus.addr;
          if (!addr_is_ram) begin
            rom_ce_d   = 1'b1;
            rom_addr_d = bus.addr;
          end
          state_d = ST_RD_ACC;
        end else if (bus.wr) begin
          if (addr_is_ram) ram_we   = 1'b1;
          else             err_ro_d = 1'b1;
          state_d = ST_WR_WAIT;
        end
      end

      ST_RD_ACC: begin
        rdata_d  = lat_is_ram ? ram_rdata : bus.rom_data;
        vld_d    = 1'b1;
        rom_ce_d = 1'b0;
        state_d  = ST_RD_HOLD;
      end

      ST_RD_HOLD: begin
        if (!bus.rd) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.wr) begin
          err_col_d = 1'b1;
        end else if (bus.addr != lat_addr_q) begin
          // Sequential fetch with rd held high: restart the access.
          vld_d      = 1'b0;
          lat_addr_d = bus.addr;
          if (!addr_is_ram) begin
            rom_ce_d   = 1'b1;
            rom_addr_d = bus.addr;
          end
          state_d = ST_RD_ACC;
        end
      end

      ST_WR_WAIT: begin
        if (!bus.wr) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lat_addr_q <= '0;
      rom_ce_q   <= 1'b0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      vld_q      <= 1'b0;
      err_ro_q   <= 1'b0;
      err_col_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      rom_ce_q   <= rom_ce_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      vld_q      <= vld_d;
      err_ro_q   <= err_ro_d;
      err_col_q  <= err_col_d;
    end
  end

  assign bus.rom_ce    = rom_ce_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = vld_q;
  assign bus.err_ro    = err_ro_q;
  assign bus.err_col   = err_col_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Saturating access counters; a read counts when RD_ACC is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (state_d == ST_RD_ACC && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (ram_we && wr_cnt_q != 16'hFFFF)              wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a combinational ROM model.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_responder_if bus_if ();

  mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // ROM contents: a few fixed words, otherwise low address byte xor 3C.
  always_comb begin
    case (bus_if.rom_addr)
      13'h0004: bus_if.rom_data = 8'hA5;
      13'h0010: bus_if.rom_data = 8'h12;
      13'h0011: bus_if.rom_data = 8'h34;
      default:  bus_if.rom_data = bus_if.rom_addr[7:0] ^ 8'h3C;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    bus_if.addr = '0; bus_if.wdata = '0;
    tick(); tick();
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_rom_ce", 32'(bus_if.rom_ce), 0);
    chk("rst_rom_addr", 32'(bus_if.rom_addr), 0);
    chk("rst_rdata", 32'(bus_if.rdata), 0);
    chk("rst_vld", 32'(bus_if.rdata_vld), 0);
    chk("rst_err_ro", 32'(bus_if.err_ro), 0);
    chk("rst_err_col", 32'(bus_if.err_col), 0);

    // ROM read after reset
    rst_n = 1'b1; bus_if.rd = 1'b1; bus_if.addr = 13'h0004;
    tick();
    chk("rd0_rom_ce", 32'(bus_if.rom_ce), 1);
    chk("rd0_rom_addr", 32'(bus_if.rom_addr), 32'h0004);
    chk("rd0_vld_early", 32'(bus_if.rdata_vld), 0);
    tick();
    chk("rd0_rom_ce_off", 32'(bus_if.rom_ce), 0);
    chk("rd0_vld", 32'(bus_if.rdata_vld), 1);
    chk("rd0_rdata", 32'(bus_if.rdata), 32'hA5);

    // rd held high across address changes
    bus_if.addr = 13'h0010;
    tick();
    chk("pc10_vld_drop", 32'(bus_if.rdata_vld), 0);
    chk("pc10_rom_addr", 32'(bus_if.rom_addr), 32'h0010);
    tick();
    chk("pc10_rdata", 32'(bus_if.rdata), 32'h12);
    bus_if.addr = 13'h0011;
    tick();
    chk("pc11_vld_drop", 32'(bus_if.rdata_vld), 0);
    chk("pc11_rdata_hold", 32'(bus_if.rdata), 32'h12);
    tick();
    chk("pc11_vld", 32'(bus_if.rdata_vld), 1);
    chk("pc11_rdata", 32'(bus_if.rdata), 32'h34);
    bus_if.rd = 1'b0;
    tick();
    chk("rdend_vld", 32'(bus_if.rdata_vld), 0);
    chk("rdend_rdata_keep", 32'(bus_if.rdata), 32'h34);
    chk("rdend_state", 32'(dut.state_q), 32'(ST_IDLE));

    // 3-cycle write pulse with data changing mid-pulse
    bus_if.wr = 1'b1; bus_if.addr = 13'h1F20; bus_if.wdata = 8'h5A;
    tick();
    chk("wr_state", 32'(dut.state_q), 32'(ST_WR_WAIT));
    bus_if.wdata = 8'hFF;
    tick(); tick();
    bus_if.wr = 1'b0;
    tick();
    chk("wr_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("wr_err_ro", 32'(bus_if.err_ro), 0);
    bus_if.rd = 1'b1;
    tick();
    chk("ramrd_rom_ce", 32'(bus_if.rom_ce), 0);
    tick();
    chk("ramrd_rom_ce2", 32'(bus_if.rom_ce), 0);
    chk("ramrd_rdata", 32'(bus_if.rdata), 32'h5A);
    bus_if.rd = 1'b0;
    tick();

    // single-cycle write, readback, then ROM at the same low byte
    bus_if.wr = 1'b1; bus_if.addr = 13'h1F21; bus_if.wdata = 8'hC3;
    tick();
    bus_if.wr = 1'b0;
    tick();
    bus_if.rd = 1'b1;
    tick(); tick();
    chk("raw_rdata", 32'(bus_if.rdata), 32'hC3);
    bus_if.addr = 13'h0020;
    tick();
    chk("alias_rom_ce", 32'(bus_if.rom_ce), 1);
    tick();
    chk("alias_rdata", 32'(bus_if.rdata), 32'h1C);
    bus_if.rd = 1'b0;
    tick();

    // write to ROM space
    bus_if.wr = 1'b1; bus_if.addr = 13'h0120; bus_if.wdata = 8'h77;
    tick();
    chk("ro_err", 32'(bus_if.err_ro), 1);
    bus_if.wr = 1'b0;
    tick(); tick();
    chk("ro_sticky", 32'(bus_if.err_ro), 1);
    bus_if.rd = 1'b1; bus_if.addr = 13'h1F20;
    tick(); tick();
    chk("ro_ram_intact", 32'(bus_if.rdata), 32'h5A);
    bus_if.rd = 1'b0;
    tick();

    // wr during RD_HOLD
    bus_if.rd = 1'b1; bus_if.addr = 13'h1F21;
    tick(); tick();
    bus_if.wr = 1'b1;
    tick();
    chk("hold_err_col", 32'(bus_if.err_col), 1);
    chk("hold_state", 32'(dut.state_q), 32'(ST_RD_HOLD));
    chk("hold_vld", 32'(bus_if.rdata_vld), 1);
    bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    tick();

    // reset during RD_ACC
    bus_if.rd = 1'b1; bus_if.addr = 13'h0004;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rstacc_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rstacc_vld", 32'(bus_if.rdata_vld), 0);
    chk("rstacc_rdata", 32'(bus_if.rdata), 0);
    chk("rstacc_err_ro", 32'(bus_if.err_ro), 0);
    chk("rstacc_err_col", 32'(bus_if.err_col), 0);
    rst_n = 1'b1; bus_if.rd = 1'b0;
    tick();

    // collision in IDLE
    bus_if.rd = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 13'h0004;
    tick();
    chk("col_err", 32'(bus_if.err_col), 1);
    chk("col_rom_ce", 32'(bus_if.rom_ce), 0);
    chk("col_state", 32'(dut.state_q), 32'(ST_IDLE));
    bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    tick();
    chk("col_sticky", 32'(bus_if.err_col), 1);

    // reset in the write cycle cancels the commit
    bus_if.wr = 1'b1; bus_if.addr = 13'h1F30; bus_if.wdata = 8'h11;
    tick();
    bus_if.wr = 1'b0;
    tick();
    rst_n = 1'b0; bus_if.wr = 1'b1; bus_if.wdata = 8'h99;
    tick();
    rst_n = 1'b1; bus_if.wr = 1'b0;
    tick();
    bus_if.rd = 1'b1;
    tick(); tick();
    chk("rstwr_keep", 32'(bus_if.rdata), 32'h11);
    bus_if.rd = 1'b0;
    tick();

`ifdef MEM_RESPONDER_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_if.wr = 1'b1; bus_if.addr = 13'h1F40; bus_if.wdata = 8'h01;
    tick();
    bus_if.wr = 1'b0;
    tick();
    bus_if.wr = 1'b1; bus_if.addr = 13'h1F41;
    tick();
    bus_if.wr = 1'b0;
    tick();
    bus_if.wr = 1'b1; bus_if.addr = 13'h0100;
    tick();
    bus_if.wr = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus_if.rd = 1'b1;
      bus_if.addr = (i == 1) ? 13'h1F40 : 13'h0004;
      tick(); tick();
      bus_if.rd = 1'b0;
      tick();
    end
    chk("stats_rd_cnt", 32'(bus_if.rd_cnt), 3);
    chk("stats_wr_cnt", 32'(bus_if.wr_cnt), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
